branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Fetch-side branch prediction table. It combines per-entry 2-bit saturating direction counters with a direct-mapped branch target buffer (BTB).
- Sits between IF and the branch resolution logic in EX.
- IF looks up the current PC combinationally and gets a taken prediction plus a next-PC.
- EX writes each resolved branch outcome back one cycle per update. It is the multi-entry successor of the single-entry 1-bit predictor FSM.

Parameters:
- XLEN, 32, PC and target width.
- INDEX_BITS, 4, log2 of entry count (ENTRIES = 2^INDEX_BITS = 16).
- TAG_BITS, XLEN-INDEX_BITS-2, stored tag width, derived; not for override.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- if_pc  input  XLEN  PC being fetched
- pred_hit  output  1  if_pc matches a valid entry
- pred_taken  output  1  predicted taken
- pred_next_pc  output  XLEN  predicted next fetch PC
- upd_en  input  1  EX resolved a branch this cycle
- upd_pc  input  XLEN  PC of the resolved branch
- upd_taken  input  1  actual outcome, 1 = taken
- upd_target  input  XLEN  actual taken target
- upd_alloc  output  1  registered pulse, a new entry was allocated on the previous edge

Behaviour:
- Addressing:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[XLEN-1:INDEX_BITS+2]
  - pc[1:0] ignored
- Per-entry state: valid (1b), tag (TAG_BITS), target (XLEN), ctr (2b).
  - ctr encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Reset (async, rst=1):
  - all valid=0, all ctr=01 (WNT), upd_alloc=0.
  - tag/target need not be cleared.
  - Outputs during reset follow the lookup rules with all entries invalid: pred_hit=0, pred_taken=0, pred_next_pc=if_pc+4.
- Lookup is combinational, zero latency:
  - pred_hit = valid[idx] & (tag[idx]==if_pc tag).
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_next_pc = pred_taken ? target[idx] : if_pc+4, addition modulo 2^XLEN.
- Update applies on the rising edge when upd_en=1; no effect when upd_en=0.
  - Hit (valid and tag match at upd_pc index):
    - ctr increments toward 11 if upd_taken, decrements toward 00 if not. It saturates at 11 and 00.
    - If upd_taken: target <= upd_target. Target is unchanged when not taken.
  - Miss and upd_taken=1: allocate, overwriting any existing entry at that index.
    - Sets valid=1, tag=upd_pc tag, target=upd_target, ctr=10 (WT).
    - upd_alloc=1 next cycle.
  - Miss and upd_taken=0: no allocation, no state change.
- upd_alloc is 1 for exactly one cycle after an allocation edge, else 0.
- Same index looked up and updated in the same cycle: the lookup sees pre-edge contents. There is no write-to-read bypass.
- Aliasing: different PCs with the same index and a different tag replace each other only via allocation on a taken miss.
- Reset asserted mid-operation (including an update in flight) wins immediately. The update on that edge is discarded.
- Update and lookup are fully independent paths. One update per cycle maximum.

Test Plan:
1. After reset, if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104, upd_alloc=0.
2. Allocation:
   - Stimulus: upd_en=1, upd_pc=0x100, upd_taken=1, upd_target=0x200 for one edge.
   - Next cycle: upd_alloc=1. Lookup if_pc=0x100 -> hit=1, taken=1 (ctr=10), next_pc=0x200.
   - Cycle after: upd_alloc=0.
3. Saturation and hysteresis, on the entry from scenario 2:
   - Three taken updates -> ctr=11.
   - One not-taken -> ctr=10, still predicts taken to 0x200.
   - Second not-taken -> ctr=01, pred_taken=0, next_pc=0x104.
   - Two more not-taken -> ctr=00, stays 00.
4. Not-taken miss: upd_pc=0x300 with upd_taken=0 -> no allocation, upd_alloc=0, lookup 0x300 hit=0.
5. Alias:
   - Stimulus: after 0x100 is allocated, taken update upd_pc=0x140 (same index 0, different tag) with target 0x500.
   - Response: 0x140 hits with next_pc 0x500; 0x100 now misses with next_pc 0x104.
6. Same-cycle read/write and reset:
   - if_pc=upd_pc=0x180 during an allocating update -> pred_hit=0 that cycle, 1 the next cycle.
   - Assert rst between edges -> pred_hit drops to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch/resolve bus of the branch target predictor: lookup from IF, update from EX.
interface branch_target_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_next_pc;
    logic            upd_en;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_alloc;

    // Fetch/execute side that drives lookups and resolved outcomes
    modport master (
        output if_pc,
        input  pred_hit,
        input  pred_taken,
        input  pred_next_pc,
        output upd_en,
        output upd_pc,
        output upd_taken,
        output upd_target,
        input  upd_alloc
    );

    // Predictor table side
    modport slave (
        input  if_pc,
        output pred_hit,
        output pred_taken,
        output pred_next_pc,
        input  upd_en,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        output upd_alloc
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry 2-bit saturating direction counters.
// Lookup is purely combinational; one resolved branch is written back per clock.
module branch_target_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 4
) (
    input logic                     clk,
    input logic                     rst,
    branch_target_predictor_if.slave bus
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

    // Counter states: 00 strongly not taken ... 11 strongly taken
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    logic [ENTRIES-1:0]  valid_q;
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic                upd_alloc_q;

    logic [INDEX_BITS-1:0] l_idx;
    logic [TAG_BITS-1:0]   l_tag;
    logic                  l_hit;
    logic                  l_taken;
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic                  unused_upd_pc_lsbs;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Byte offset within a word never selects an entry
    assign unused_upd_pc_lsbs = &{1'b0, bus.upd_pc[1:0]};

    // Fetch-side lookup: sees table contents from before the current edge
    always_comb begin
        l_idx   = bus.if_pc[INDEX_BITS+1:2];
        l_tag   = bus.if_pc[XLEN-1:INDEX_BITS+2];
        l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        l_taken = l_hit && ctr_q[l_idx][1];
    end

    assign bus.pred_hit     = l_hit;
    assign bus.pred_taken   = l_taken;
    assign bus.pred_next_pc = l_taken ? target_q[l_idx] : bus.if_pc + XLEN'(4);
    assign bus.upd_alloc    = upd_alloc_q;

    // Resolve-side address decode and hit detection for the update port
    always_comb begin
        u_idx = bus.upd_pc[INDEX_BITS+1:2];
        u_tag = bus.upd_pc[XLEN-1:INDEX_BITS+2];
        u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    end

    // Control state: valid bits, direction counters and the allocation pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            upd_alloc_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            upd_alloc_q <= 1'b0;
            if (bus.upd_en) begin
                if (u_hit) begin
                    ctr_q[u_idx] <= bus.upd_taken ? ctr_inc(ctr_q[u_idx]) : ctr_dec(ctr_q[u_idx]);
                end else if (bus.upd_taken) begin
                    valid_q[u_idx] <= 1'b1;
                    ctr_q[u_idx]   <= CTR_WT;
                    upd_alloc_q    <= 1'b1;
                end
            end
        end
    end

    // Tag/target payload: any taken resolution either refreshes a hit or allocates;
    // left unreset because a cleared valid bit hides whatever it holds
    always_ff @(posedge clk) begin
        if (bus.upd_en && bus.upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.upd_target;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;
    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    branch_target_predictor_if #(.XLEN(XLEN)) bif ();

    branch_target_predictor #(.XLEN(XLEN), .INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One resolved branch across a single rising edge; returns 1 ns after the edge
    task automatic update(input logic [XLEN-1:0] pc, input logic taken, input logic [XLEN-1:0] tgt);
        bif.upd_en     = 1'b1;
        bif.upd_pc     = pc;
        bif.upd_taken  = taken;
        bif.upd_target = tgt;
        @(posedge clk);
        #1;
        bif.upd_en = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [XLEN-1:0] pc, input logic hit,
                          input logic taken, input logic [XLEN-1:0] nxt);
        bif.if_pc = pc;
        #1;
        check({tag, "_hit"},   XLEN'(bif.pred_hit),   XLEN'(hit));
        check({tag, "_taken"}, XLEN'(bif.pred_taken), XLEN'(taken));
        check({tag, "_next"},  bif.pred_next_pc,      nxt);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bif.if_pc      = 32'h100;
        bif.upd_en     = 1'b0;
        bif.upd_pc     = '0;
        bif.upd_taken  = 1'b0;
        bif.upd_target = '0;

        // Reset state
        lookup("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        check("rst_alloc", XLEN'(bif.upd_alloc), 0);
        @(negedge clk);
        rst = 1'b0;
        lookup("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);

        // Allocation on a taken miss
        update(32'h100, 1'b1, 32'h200);
        check("alloc_pulse", XLEN'(bif.upd_alloc), 1);
        lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        @(posedge clk); #1;
        check("alloc_pulse_end", XLEN'(bif.upd_alloc), 0);

        // Saturate high: 10 -> 11 -> 11 -> 11
        update(32'h100, 1'b1, 32'h200);
        check("hit_no_alloc", XLEN'(bif.upd_alloc), 0);
        update(32'h100, 1'b1, 32'h200);
        update(32'h100, 1'b1, 32'h200);
        // 11 -> 10: still taken, target untouched by a not-taken update
        update(32'h100, 1'b0, 32'h999);
        lookup("ctr10", 32'h100, 1'b1, 1'b1, 32'h200);
        // 10 -> 01
        update(32'h100, 1'b0, 32'h999);
        lookup("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        // 01 -> 00 -> 00
        update(32'h100, 1'b0, 32'h999);
        update(32'h100, 1'b0, 32'h999);
        lookup("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);
        // 00 -> 01: proves the low end held at 00
        update(32'h100, 1'b1, 32'h200);
        lookup("ctr00_up", 32'h100, 1'b1, 1'b0, 32'h104);
        // 01 -> 10 with a new target: taken hit refreshes target
        update(32'h100, 1'b1, 32'h240);
        lookup("retarget", 32'h100, 1'b1, 1'b1, 32'h240);

        // Not-taken miss leaves the table alone
        update(32'h300, 1'b0, 32'h700);
        check("nt_miss_alloc", XLEN'(bif.upd_alloc), 0);
        lookup("nt_miss", 32'h300, 1'b0, 1'b0, 32'h304);

        // Alias at index 0 replaces 0x100
        update(32'h140, 1'b1, 32'h500);
        check("alias_alloc", XLEN'(bif.upd_alloc), 1);
        lookup("alias_new", 32'h140, 1'b1, 1'b1, 32'h500);
        lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        // Fresh entry starts at 10, so one not-taken drops prediction
        update(32'h140, 1'b0, 32'h0);
        lookup("alias_ctr", 32'h140, 1'b1, 1'b0, 32'h144);

        // Same-cycle lookup and allocating update: no bypass
        bif.if_pc      = 32'h180;
        bif.upd_en     = 1'b1;
        bif.upd_pc     = 32'h180;
        bif.upd_taken  = 1'b1;
        bif.upd_target = 32'h600;
        #1;
        check("same_cycle_hit", XLEN'(bif.pred_hit), 0);
        @(posedge clk); #1;
        bif.upd_en = 1'b0;
        lookup("after_edge", 32'h180, 1'b1, 1'b1, 32'h600);

        // Asynchronous reset between edges
        rst = 1'b1;
        #1;
        check("async_rst_hit", XLEN'(bif.pred_hit), 0);
        check("async_rst_next", bif.pred_next_pc, 32'h184);
        check("async_rst_alloc", XLEN'(bif.upd_alloc), 0);

        // Update presented while reset is held is discarded
        update(32'h380, 1'b1, 32'h800);
        check("rst_upd_alloc", XLEN'(bif.upd_alloc), 0);
        @(negedge clk);
        rst = 1'b0;
        lookup("rst_upd", 32'h380, 1'b0, 1'b0, 32'h384);
        lookup("rst_cleared", 32'h180, 1'b0, 1'b0, 32'h184);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
